// File: rtl/road_light_driver_pkg.sv
// Shared junction definitions: FSM state encoding and default interval/size constants.
package road_light_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ALL_RED = 2'd1,
        ST_GREEN   = 2'd2,
        ST_YELLOW  = 2'd3
    } state_t;

    localparam int DEF_NUM_ROADS      = 4;
    localparam int DEF_ROAD_W         = 2;
    localparam int DEF_YELLOW_CYCLES  = 3;
    localparam int DEF_ALL_RED_CYCLES = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/road_light_driver_if.sv
// Road request in from the lane-timing counter, per-road lamp drives and status out.
interface road_light_driver_if #(
    parameter int NUM_ROADS = 4,
    parameter int ROAD_W    = 2
);
    logic                 light_en;
    logic [ROAD_W-1:0]    road_sel;
    logic [NUM_ROADS-1:0] green;
    logic [NUM_ROADS-1:0] yellow;
    logic [NUM_ROADS-1:0] red;
    logic [ROAD_W-1:0]    active_road;
    logic                 busy;

    modport master (
        output light_en, road_sel,
        input  green, yellow, red, active_road, busy
    );

    modport slave (
        input  light_en, road_sel,
        output green, yellow, red, active_road, busy
    );
endinterface

// File: rtl/road_light_driver_lamp_decode.sv
// Combinational lamp decode: state + owning road -> red/yellow/green vectors.
module road_lamp_decode
    import road_light_driver_pkg::*;
#(
    parameter int NUM_ROADS = 4,
    parameter int ROAD_W    = 2
) (
    input  state_t               state,
    input  logic [ROAD_W-1:0]    active_road,
    output logic [NUM_ROADS-1:0] green,
    output logic [NUM_ROADS-1:0] yellow,
    output logic [NUM_ROADS-1:0] red
);

    always_comb begin
        green  = '0;
        yellow = '0;
        for (int i = 0; i < NUM_ROADS; i++) begin
            if (active_road == ROAD_W'(i)) begin
                green[i]  = (state == ST_GREEN);
                yellow[i] = (state == ST_YELLOW);
            end
        end
        // Red is the complement so each road always shows exactly one lamp.
        red = ~(green | yellow);
    end

endmodule

// File: rtl/road_light_driver.sv
// Junction lamp sequencer: GREEN -> YELLOW -> ALL_RED -> GREEN on each handover.
// Lamps are decoded from the next state and registered, so a request shows one cycle later.
module road_light_driver
    import road_light_driver_pkg::*;
#(
    parameter int NUM_ROADS      = DEF_NUM_ROADS,
    parameter int ROAD_W         = DEF_ROAD_W,
    parameter int YELLOW_CYCLES  = DEF_YELLOW_CYCLES,
    parameter int ALL_RED_CYCLES = DEF_ALL_RED_CYCLES
) (
    input  logic clk,
    input  logic rst,
    road_light_driver_if.slave bus
);

    localparam int TIMER_W = $clog2(max_int(YELLOW_CYCLES, ALL_RED_CYCLES) + 1);
    localparam logic [TIMER_W-1:0] Y_LOAD  = TIMER_W'(YELLOW_CYCLES - 1);
    localparam logic [TIMER_W-1:0] AR_LOAD = TIMER_W'(ALL_RED_CYCLES - 1);
    localparam logic [ROAD_W:0]    NUM_LIM = (ROAD_W + 1)'(NUM_ROADS);

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [ROAD_W-1:0]    active_q, active_d;
    logic                 busy_q, busy_d;
    logic [NUM_ROADS-1:0] green_q, yellow_q, red_q;
    logic [NUM_ROADS-1:0] green_d, yellow_d, red_d;
    logic                 sel_valid;

    assign sel_valid = ({1'b0, bus.road_sel} < NUM_LIM);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        active_d = active_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.light_en) begin
                    state_d = ST_ALL_RED;
                    timer_d = AR_LOAD;
                end
            end
            ST_ALL_RED: begin
                if (timer_q == '0) begin
                    if (bus.light_en) begin
                        state_d = ST_GREEN;
                        // An out-of-range request re-greens the previous road.
                        if (sel_valid) active_d = bus.road_sel;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            ST_GREEN: begin
                if (!bus.light_en || (sel_valid && (bus.road_sel != active_q))) begin
                    state_d = ST_YELLOW;
                    timer_d = Y_LOAD;
                end
            end
            ST_YELLOW: begin
                if (timer_q == '0) begin
                    state_d = ST_ALL_RED;
                    timer_d = AR_LOAD;
                end else begin
                    timer_d = timer_q - TIMER_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_ALL_RED) || (state_d == ST_YELLOW);
    end

    road_lamp_decode #(
        .NUM_ROADS (NUM_ROADS),
        .ROAD_W    (ROAD_W)
    ) u_decode (
        .state       (state_d),
        .active_road (active_d),
        .green       (green_d),
        .yellow      (yellow_d),
        .red         (red_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            active_q <= '0;
            busy_q   <= 1'b0;
            green_q  <= '0;
            yellow_q <= '0;
            red_q    <= '1;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            active_q <= active_d;
            busy_q   <= busy_d;
            green_q  <= green_d;
            yellow_q <= yellow_d;
            red_q    <= red_d;
        end
    end

    assign bus.green       = green_q;
    assign bus.yellow      = yellow_q;
    assign bus.red         = red_q;
    assign bus.active_road = active_q;
    assign bus.busy        = busy_q;

endmodule
